// File: rtl/dioptase_pkg.sv
// dioptase_pkg: shared fetch-entry type, exception/error constants and width helper
package dioptase_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int EXC_W_DEF  = 8;
    localparam logic [EXC_W_DEF-1:0] EXC_NONE = '0;
    localparam int ERR_OVF  = 0;
    localparam int ERR_SPUR = 1;
    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]   pc;
        logic                  bubble;
        logic [EXC_W_DEF-1:0]  exc;
    } fetch_entry_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/decode_ibuf_if.sv
// decode_ibuf_if: fetch credit, memory response, decode output and error signals
interface decode_ibuf_if import dioptase_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int EXC_W  = EXC_W_DEF
);
    logic              halt;
    logic              flush;
    logic              fetch_ready;
    logic              fetch_issue;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_instr;
    logic [PC_W-1:0]   rsp_pc;
    logic              rsp_bubble;
    logic [EXC_W-1:0]  rsp_exc;
    logic              decode_stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;
    logic              out_bubble;
    logic [EXC_W-1:0]  out_exc;
    logic [1:0]        err_sticky;
    modport master (
        output halt, flush, fetch_issue, rsp_valid, rsp_instr, rsp_pc, rsp_bubble, rsp_exc, decode_stall,
        input  fetch_ready, out_valid, out_instr, out_pc, out_bubble, out_exc, err_sticky
    );
    modport slave (
        input  halt, flush, fetch_issue, rsp_valid, rsp_instr, rsp_pc, rsp_bubble, rsp_exc, decode_stall,
        output fetch_ready, out_valid, out_instr, out_pc, out_bubble, out_exc, err_sticky
    );
endinterface

// File: rtl/decode_ibuf_ring.sv
// ibuf_ring: DEPTH-entry circular storage with wrapping pointers, push/pop/clear
module ibuf_ring #(
    parameter int DEPTH = 3,
    parameter int W     = 73,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    // Pointer and occupancy update; clear overrides push and pop.
    always_ff @(posedge clk or posedge rst)
        if (rst || i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= nxt(r_wr);
            if (i_pop) r_rd <= nxt(r_rd);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    // Entry storage; contents are only observed while counted, so no reset.
    always_ff @(posedge clk)
        if (i_push && !i_clear) r_mem[r_wr] <= i_wdata;
    assign o_rdata = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
endmodule

// File: rtl/decode_ibuf.sv
// decode_ibuf: credit-based instruction-return FIFO between fetch memory and decode.
// Optional same-cycle response bypass when the queue is empty: DECODE_IBUF_BYPASS_EN.
module decode_ibuf import dioptase_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int EXC_W  = EXC_W_DEF,
    parameter int LAT    = 2,
    parameter int DEPTH  = LAT + 1
) (
    input  logic         clk,
    input  logic         rst,
    decode_ibuf_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int EW = DATA_W + PC_W + 1 + EXC_W;
    logic [CW-1:0] r_inflight, r_drop_cnt, w_count;
    logic [1:0]    r_err;
    logic [EW-1:0] w_rsp_ent, w_head, w_out;
    logic w_ready, w_spur, w_rsp_ok, w_keep, w_byp, w_pop, w_pop_q, w_push, w_push_q, w_full, w_ovf;
    assign w_ready  = !bus.halt && !bus.flush && ({1'b0, w_count} + {1'b0, r_inflight} < (CW + 1)'(DEPTH));
    assign w_spur   = bus.rsp_valid && r_inflight == '0;
    assign w_rsp_ok = bus.rsp_valid && !w_spur;
    assign w_keep   = w_rsp_ok && r_drop_cnt == '0 && !bus.flush;
`ifdef DECODE_IBUF_BYPASS_EN
    assign w_byp = w_keep && w_count == '0;
`else
    assign w_byp = 1'b0;
`endif
    assign w_rsp_ent = {bus.rsp_instr, bus.rsp_pc, bus.rsp_bubble, bus.rsp_exc};
    assign w_out = w_byp ? w_rsp_ent :
                   (w_count != '0) ? w_head : {{(DATA_W + PC_W){1'b0}}, 1'b1, EXC_W'(EXC_NONE)};
    assign {bus.out_instr, bus.out_pc, bus.out_bubble, bus.out_exc} = w_out;
    assign bus.out_valid   = w_count != '0 || w_byp;
    assign bus.fetch_ready = w_ready;
    assign bus.err_sticky  = r_err;
    assign w_pop    = bus.out_valid && !bus.decode_stall && !bus.halt && !bus.flush;
    assign w_pop_q  = w_pop && w_count != '0;
    assign w_push   = w_keep && !(w_byp && w_pop);
    assign w_ovf    = w_push && w_full && !w_pop_q;
    assign w_push_q = w_push && !w_ovf;
    ibuf_ring #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.flush),
        .i_push  (w_push_q),
        .i_pop   (w_pop_q),
        .i_wdata (w_rsp_ent),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );
    // Outstanding-read credits, flush drop accounting and sticky error capture.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_err      <= '0;
        end else begin
            r_inflight      <= r_inflight + CW'(bus.fetch_issue && w_ready) - CW'(w_rsp_ok);
            r_drop_cnt      <= bus.flush ? r_drop_cnt + r_inflight - CW'(w_rsp_ok)
                                         : r_drop_cnt - CW'(w_rsp_ok && r_drop_cnt != '0);
            r_err[ERR_OVF]  <= r_err[ERR_OVF] | (bus.fetch_issue && !w_ready) | w_ovf;
            r_err[ERR_SPUR] <= r_err[ERR_SPUR] | w_spur;
        end
endmodule

// File: tb/tb_decode_ibuf.sv
// tb_decode_ibuf: directed + randomized bench with a queue-level reference model
module tb_decode_ibuf;
    import dioptase_pkg::*;
    localparam int LAT = 2;
    localparam int DEPTH = 3;
`ifdef DECODE_IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam fetch_entry_t DEF = '{instr: 32'h0, pc: 32'h0, bubble: 1'b1, exc: 8'h0};
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    decode_ibuf_if #(.DATA_W(32), .PC_W(32), .EXC_W(8)) bus ();
    decode_ibuf #(.DATA_W(32), .PC_W(32), .EXC_W(8), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int checks = 0;
    int failures = 0;
    fetch_entry_t q[$];
    int infl, drop;
    logic [1:0] merr;
    bit slot_v[LAT];
    fetch_entry_t slot_e[LAT];
    logic [31:0] next_pc, redirect_pc, obs_pc, held_pc;
    bit obs_valid, found;
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask
    task automatic model_reset();
        q.delete();
        infl = 0;
        drop = 0;
        merr = 2'b00;
        next_pc = 32'h0;
        redirect_pc = 32'h0;
        for (int i = 0; i < LAT; i++) slot_v[i] = 1'b0;
    endtask
    task automatic step(input bit iss, input bit st, input bit hl, input bit fl, input bit obey, input bit frsp);
        fetch_entry_t re, ee, ne;
        bit rv, spur, ok, keep, byp, ev, er, acc, pop;
        int n;
        n = q.size();
        er = !hl && !fl && (n + infl < DEPTH);
        if (obey) iss = iss && er;
        rv = slot_v[LAT-1] || frsp;
        re = slot_v[LAT-1] ? slot_e[LAT-1] : '{instr: 32'hDEAD_BEEF, pc: 32'h40, bubble: 1'b0, exc: 8'h0};
        bus.fetch_issue = iss;
        bus.decode_stall = st;
        bus.halt = hl;
        bus.flush = fl;
        bus.rsp_valid = rv;
        bus.rsp_instr = re.instr;
        bus.rsp_pc = re.pc;
        bus.rsp_bubble = re.bubble;
        bus.rsp_exc = re.exc;
        #1;
        spur = rv && infl == 0;
        ok = rv && !spur;
        keep = ok && !fl && drop == 0;
        byp = BYP && keep && n == 0;
        ev = n > 0 || byp;
        ee = n > 0 ? q[0] : byp ? re : DEF;
        chk("out_valid", bus.out_valid, ev);
        chk("out_pc", bus.out_pc, ee.pc);
        chk("out_instr", bus.out_instr, ee.instr);
        chk("out_bubble", bus.out_bubble, ee.bubble);
        chk("out_exc", bus.out_exc, ee.exc);
        chk("fetch_ready", bus.fetch_ready, er);
        chk("err_sticky", bus.err_sticky, merr);
        obs_valid = bus.out_valid;
        obs_pc = bus.out_pc;
        @(posedge clk);
        acc = iss && er;
        if (iss && !er) merr[0] = 1'b1;
        if (spur) merr[1] = 1'b1;
        if (fl) begin
            drop = drop + infl - int'(ok);
            q.delete();
            next_pc = redirect_pc;
        end else begin
            pop = ev && !st && !hl;
            if (ok && drop > 0) drop--;
            else if (ok) begin
                if (n < DEPTH || (pop && n > 0)) q.push_back(re);
                else merr[0] = 1'b1;
            end
            if (pop) void'(q.pop_front());
        end
        infl = infl + int'(acc) - int'(ok);
        for (int i = LAT - 1; i > 0; i--) begin
            slot_v[i] = slot_v[i-1];
            slot_e[i] = slot_e[i-1];
        end
        slot_v[0] = acc;
        if (acc) begin
            ne.instr = $urandom;
            ne.pc = next_pc;
            ne.bubble = ($urandom % 4) == 0;
            ne.exc = (($urandom % 5) == 0) ? 8'($urandom) : 8'h0;
            slot_e[0] = ne;
            next_pc = next_pc + 32'd4;
        end
        @(negedge clk);
    endtask
    task automatic idle_inputs();
        bus.fetch_issue = 1'b0;
        bus.decode_stall = 1'b0;
        bus.halt = 1'b0;
        bus.flush = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_instr = '0;
        bus.rsp_pc = '0;
        bus.rsp_bubble = 1'b0;
        bus.rsp_exc = '0;
    endtask
    initial begin
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_bubble", bus.out_bubble, 1'b1);
        chk("rst_out_exc", bus.out_exc, 8'h0);
        chk("rst_fetch_ready", bus.fetch_ready, 1'b1);
        chk("rst_err", bus.err_sticky, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) step(1, 0, 0, 0, 1, 0);
        repeat (4) step(1, 1, 0, 0, 1, 0);
        repeat (6) step(1, 0, 0, 0, 1, 0);
        chk("stall_err", bus.err_sticky, 2'b00);
        redirect_pc = 32'h100;
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0, 0, 0, 1, 0);
            found = obs_valid;
        end
        chk("flush_found", found, 1'b1);
        chk("flush_pc", obs_pc, 32'h100);
        repeat (6) step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        redirect_pc = 32'h200;
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0, 0, 0, 1, 0);
            found = obs_valid;
        end
        chk("flushrsp_found", found, 1'b1);
        chk("flushrsp_pc", obs_pc, 32'h200);
        repeat (6) step(0, 0, 0, 0, 1, 0);
        next_pc = 32'h40;
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("byp_same_valid", obs_valid, BYP);
        chk("byp_same_pc", obs_pc, BYP ? 32'h40 : 32'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("byp_next_valid", obs_valid, !BYP);
        chk("byp_next_pc", obs_pc, BYP ? 32'h0 : 32'h40);
        repeat (3) step(1, 1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 1, 0);
        held_pc = obs_pc;
        chk("halt_valid0", obs_valid, 1'b1);
        repeat (2) begin
            step(1, 0, 1, 0, 1, 0);
            chk("halt_pc_stable", obs_pc, held_pc);
            chk("halt_valid", obs_valid, 1'b1);
        end
        repeat (400) begin
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            step(($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 10) == 0, ($urandom % 20) == 0, 1, 0);
        end
        repeat (8) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("err_spur", bus.err_sticky, 2'b10);
        step(1, 0, 1, 0, 0, 0);
        chk("err_both", bus.err_sticky, 2'b11);
        repeat (4) step(1, 0, 0, 0, 1, 0);
        chk("err_persist", bus.err_sticky, 2'b11);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_bubble", bus.out_bubble, 1'b1);
        chk("arst_fetch_ready", bus.fetch_ready, 1'b1);
        chk("arst_err", bus.err_sticky, 2'b00);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (8) step(1, 0, 0, 0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
